// File: rtl/cdc_gray_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// cdc_gray_rd_ptr_ctrl
//
// Read-side pointer controller for a dual-clock FIFO. The write domain's Gray
// pointer is brought into the read clock domain through a plain flop chain and
// converted to binary. The controller also keeps the local read pointer in
// binary and Gray form. From these two pointers it derives the empty flag, the
// almost-empty flag, the fill level and the RAM read address.
//
// Parameters:
//   n_bits       pointer width including the wrap bit (depth = 2**(n_bits-1))
//   SYNC_STAGES  number of synchroniser flops on wrPtrGray
//   AE_LEVEL     almostEmpty asserts when level <= AE_LEVEL
//
// Ports:
//   clk          read-domain clock; all state updates on its rising edge
//   sysRst       synchronous, active-high reset
//   wrPtrGray    write-domain Gray pointer (asynchronous to clk)
//   rdReq        consumer requests a pop this cycle
//   rdEn         pop accepted this cycle; drives the RAM read enable
//   rdAddr       RAM read address (low bits of the binary read pointer)
//   rdPtrGray    registered Gray read pointer, returned to the write domain
//   empty        no entries visible to the read side
//   almostEmpty  level <= AE_LEVEL
//   level        visible occupancy, 0 .. 2**(n_bits-1)
// -----------------------------------------------------------------------------
module cdc_gray_rd_ptr_ctrl #(
    parameter int n_bits      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_LEVEL    = 1
) (
    input  logic              clk,
    input  logic              sysRst,
    input  logic [n_bits-1:0] wrPtrGray,
    input  logic              rdReq,
    output logic              rdEn,
    output logic [n_bits-2:0] rdAddr,
    output logic [n_bits-1:0] rdPtrGray,
    output logic              empty,
    output logic              almostEmpty,
    output logic [n_bits-1:0] level
);

    // One extra bit so that AE_LEVEL = 2**(n_bits-1) can never truncate.
    localparam logic [n_bits:0] AeLevel = (n_bits + 1)'(AE_LEVEL);

    logic [n_bits-1:0] syncChain [SYNC_STAGES];
    logic [n_bits-1:0] wrGraySync;
    logic [n_bits-1:0] wrBinSync;
    logic [n_bits-1:0] rdBin;
    logic [n_bits-1:0] rdBinNext;
    logic [n_bits-1:0] rdGrayNext;

    // -------------------------------------------------------------------------
    // Synchroniser: plain flops only. Any logic between the stages would put
    // glitches on the metastability path.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sysRst) begin
            // NOTE: this small flop array is reset explicitly. It is not a RAM,
            // and a known value here is what makes empty=1 right after reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncChain[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample its
            // predecessor's old value. With blocking assignments the chain
            // would collapse into a single flop.
            syncChain[0] <= wrPtrGray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncChain[i] <= syncChain[i-1];
            end
        end
    end

    assign wrGraySync = syncChain[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Gray to binary: each binary bit is the XOR of all Gray bits at and above
    // its position. Written as a reduction so that no bit of the vector
    // depends on another bit of the same vector.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the loop keeps the block
        // combinational even if the loop bounds are edited later.
        wrBinSync = '0;
        for (int i = 0; i < n_bits; i++) begin
            wrBinSync[i] = ^(wrGraySync >> i);
        end
    end

    // -------------------------------------------------------------------------
    // Flags and level. These depend only on registers (and rdReq, for rdEn),
    // so they never glitch from the asynchronous input.
    // -------------------------------------------------------------------------
    assign empty       = (rdPtrGray == wrGraySync);
    // Modulo subtraction handles the pointer wrap without any special case.
    assign level       = wrBinSync - rdBin;
    assign almostEmpty = ({1'b0, level} <= AeLevel);
    assign rdEn        = rdReq & ~empty;
    assign rdAddr      = rdBin[n_bits-2:0];

    // -------------------------------------------------------------------------
    // Read pointer. The Gray copy is registered directly, not decoded from
    // rdBin after the flop, so the write domain only ever sees a one-bit
    // change per edge.
    // -------------------------------------------------------------------------
    assign rdBinNext  = rdBin + n_bits'(1);
    assign rdGrayNext = rdBinNext ^ (rdBinNext >> 1);

    always_ff @(posedge clk) begin
        if (sysRst) begin
            rdBin     <= '0;
            rdPtrGray <= '0;
        end else if (rdEn) begin
            rdBin     <= rdBinNext;
            rdPtrGray <= rdGrayNext;
        end
    end

endmodule

// File: tb/tb_cdc_gray_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cdc_gray_rd_ptr_ctrl (n_bits=4, SYNC_STAGES=2, AE_LEVEL=1).
// The vector table holds hand-derived expected outputs. These are pushed to a
// scoreboard queue when each vector is driven, then popped and compared at the
// falling edge of the same cycle. A hand-written streaming sequence covers the
// pointer wrap.
// -----------------------------------------------------------------------------
module tb_cdc_gray_rd_ptr_ctrl;

    logic       clk = 1'b0;
    logic       sysRst;
    logic [3:0] wrPtrGray;
    logic       rdReq;
    logic       rdEn;
    logic [2:0] rdAddr;
    logic [3:0] rdPtrGray;
    logic       empty;
    logic       almostEmpty;
    logic [3:0] level;

    cdc_gray_rd_ptr_ctrl #(
        .n_bits     (4),
        .SYNC_STAGES(2),
        .AE_LEVEL   (1)
    ) dut (
        .clk        (clk),
        .sysRst     (sysRst),
        .wrPtrGray  (wrPtrGray),
        .rdReq      (rdReq),
        .rdEn       (rdEn),
        .rdAddr     (rdAddr),
        .rdPtrGray  (rdPtrGray),
        .empty      (empty),
        .almostEmpty(almostEmpty),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       empty;
        logic       almostEmpty;
        logic       rdEn;
        logic [2:0] rdAddr;
        logic [3:0] rdPtrGray;
        logic [3:0] level;
    } out_t;

    typedef struct {
        logic       rst;
        logic [3:0] wg;
        logic       req;
        logic       chk;
        out_t       exp;
    } vec_t;

    typedef struct {
        int   idx;
        out_t exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   nChecks = 0;
    int   nFails  = 0;

    function automatic logic [3:0] gray(int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected-output order: empty, almostEmpty, rdEn, rdAddr, rdPtrGray, level
    function automatic void add(logic rst, logic [3:0] wg, logic req,
                                logic e, logic ae, logic en, logic [2:0] addr,
                                logic [3:0] rpg, logic [3:0] lvl, logic chk = 1'b1);
        vec_t v;
        v.rst = rst;
        v.wg  = wg;
        v.req = req;
        v.chk = chk;
        v.exp = '{empty: e, almostEmpty: ae, rdEn: en, rdAddr: addr,
                  rdPtrGray: rpg, level: lvl};
        vecs.push_back(v);
    endfunction

    // Inputs change 1 time unit after the rising edge. Outputs are checked at
    // the following falling edge.
    task automatic run_vectors(int first, int last);
        for (int i = first; i <= last; i++) begin
            sysRst    = vecs[i].rst;
            wrPtrGray = vecs[i].wg;
            rdReq     = vecs[i].req;
            if (vecs[i].chk) sb.push_back('{idx: i, exp: vecs[i].exp});
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t  e;
            out_t act;
            e   = sb.pop_front();
            act = '{empty: empty, almostEmpty: almostEmpty, rdEn: rdEn,
                    rdAddr: rdAddr, rdPtrGray: rdPtrGray, level: level};
            check($sformatf("vec%0d", e.idx), 32'(act), 32'(e.exp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         part1End;
        logic [3:0] prevGray;
        logic       seen8;
        logic       seenWrap;
        logic       drained;

        // ---------------- Part 1: reset, latency, level, underflow ---------
        add(1, 4'h0, 1, 1, 1, 0, 3'd0, 4'h0, 4'd0, 1'b0);   // power-up, state unknown
        add(1, 4'h0, 1, 1, 1, 0, 3'd0, 4'h0, 4'd0);         // reset held, rdReq=1
        add(1, 4'h0, 1, 1, 1, 0, 3'd0, 4'h0, 4'd0);
        // Latency: Gray(1) sampled at edge k, visible after edge k+1
        add(0, 4'h1, 0, 1, 1, 0, 3'd0, 4'h0, 4'd0);         // edge k follows
        add(0, 4'h1, 0, 1, 1, 0, 3'd0, 4'h0, 4'd0);         // edge k+1 follows
        add(0, 4'h1, 0, 0, 1, 0, 3'd0, 4'h0, 4'd1);         // level=1 now
        add(0, 4'h1, 1, 0, 1, 1, 3'd0, 4'h0, 4'd1);         // pop accepted
        add(0, 4'h1, 1, 1, 1, 0, 3'd1, 4'h1, 4'd0);         // empty again, rdPtrGray=0001
        // Reset, then Gray(5)=0111 held
        add(1, 4'h7, 0, 1, 1, 0, 3'd1, 4'h1, 4'd0);
        add(0, 4'h7, 0, 1, 1, 0, 3'd0, 4'h0, 4'd0);
        add(0, 4'h7, 0, 1, 1, 0, 3'd0, 4'h0, 4'd0);
        add(0, 4'h7, 0, 0, 0, 0, 3'd0, 4'h0, 4'd5);         // level=5, almostEmpty=0
        add(0, 4'h7, 1, 0, 0, 1, 3'd0, 4'h0, 4'd5);
        add(0, 4'h7, 1, 0, 0, 1, 3'd1, 4'h1, 4'd4);
        add(0, 4'h7, 1, 0, 0, 1, 3'd2, 4'h3, 4'd3);
        add(0, 4'h7, 1, 0, 0, 1, 3'd3, 4'h2, 4'd2);         // level 2: almostEmpty still 0
        add(0, 4'h7, 0, 0, 1, 0, 3'd4, 4'h6, 4'd1);         // level 1: almostEmpty=1
        add(0, 4'h7, 1, 0, 1, 1, 3'd4, 4'h6, 4'd1);         // last entry popped
        // Underflow: rdReq held while empty, pointers must hold
        for (int i = 0; i < 11; i++) add(0, 4'h7, 1, 1, 1, 0, 3'd5, 4'h7, 4'd0);
        part1End = vecs.size() - 1;

        // ---------------- Part 2: full level and mid-operation reset -------
        add(1, 4'hC, 0, 1, 1, 0, 3'd5, 4'hB, 4'd0, 1'b0);   // reset after the wrap stream
        add(0, 4'hC, 0, 1, 1, 0, 3'd0, 4'h0, 4'd0);
        add(0, 4'hC, 0, 1, 1, 0, 3'd0, 4'h0, 4'd0);
        add(0, 4'hC, 0, 0, 0, 0, 3'd0, 4'h0, 4'd8);         // full: level=8
        add(1, 4'hC, 1, 0, 0, 1, 3'd0, 4'h0, 4'd8);         // reset wins over the pop
        add(0, 4'hC, 1, 1, 1, 0, 3'd0, 4'h0, 4'd0);         // pointer state discarded
        add(0, 4'hC, 1, 1, 1, 0, 3'd0, 4'h0, 4'd0);
        add(0, 4'hC, 1, 0, 0, 1, 3'd0, 4'h0, 4'd8);         // sync reloaded
        add(0, 4'hC, 0, 0, 0, 0, 3'd1, 4'h1, 4'd7);

        run_vectors(0, part1End);

        // ---------------- Wrap: stream 40 entries, continuous pop ----------
        // Read pointer starts at 5, so 40 more writes end at 45 = 13 mod 16.
        sysRst   = 1'b0;
        rdReq    = 1'b1;
        seen8    = 1'b0;
        seenWrap = 1'b0;
        @(negedge clk);
        prevGray = rdPtrGray;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            wrPtrGray = gray(5 + i);
            @(negedge clk);
            check("wrap_gray_step", 32'($countones(rdPtrGray ^ prevGray) <= 1), 32'd1);
            check("wrap_level_max", 32'(level <= 4'd8), 32'd1);
            if (rdPtrGray == 4'b1000) seen8 = 1'b1;
            if (seen8 && rdPtrGray == 4'b0000) seenWrap = 1'b1;
            prevGray = rdPtrGray;
        end
        drained = 1'b0;
        for (int c = 0; c < 12 && !drained; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("drain_gray_step", 32'($countones(rdPtrGray ^ prevGray) <= 1), 32'd1);
            prevGray = rdPtrGray;
            drained  = empty;
        end
        check("wrap_drained", 32'(drained), 32'd1);
        check("wrap_final_gray", 32'(rdPtrGray), 32'(gray(45)));
        check("wrap_final_level", 32'(level), 32'd0);
        check("wrap_final_addr", 32'(rdAddr), 32'd5);
        check("wrap_rolled_over", 32'(seenWrap), 32'd1);
        @(posedge clk);
        #1;

        run_vectors(part1End + 1, vecs.size() - 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/cdc_gray_rd_ptr_ctrl.md
Name: cdc_gray_rd_ptr_ctrl

Overview:
- Read-side pointer controller for the dual-clock FIFOs in the AXI4 convertors. It receives the write-domain Gray pointer and synchronises it into the read clock domain.
- It converts the synchronised pointer to binary and maintains the local read pointer in binary and Gray form. From these it derives empty, almost-empty, fill level and the RAM read address.
- It is the consumer end of the Gray-pointer crossing; the write domain's Gray counter is the producer end.

Parameters:
- n_bits, 4: pointer width including the wrap bit. FIFO depth = 2^(n_bits-1). Legal range 2..16.
- SYNC_STAGES, 2: number of synchroniser flops on the incoming Gray pointer. Legal range 2..4.
- AE_LEVEL, 1: almostEmpty asserts when level <= AE_LEVEL. Legal range 0..2^(n_bits-1).

Ports:
- clk  in  1  read-domain clock; all state updates on its rising edge.
- sysRst  in  1  synchronous, active-high reset.
- wrPtrGray  in  n_bits  write-domain Gray pointer; asynchronous to clk.
- rdReq  in  1  consumer requests a pop this cycle.
- rdEn  out  1  pop accepted; drives the RAM read enable.
- rdAddr  out  n_bits-1  RAM read address (low bits of the binary read pointer).
- rdPtrGray  out  n_bits  registered Gray read pointer, returned to the write domain.
- empty  out  1  no entries visible to the read side.
- almostEmpty  out  1  level <= AE_LEVEL.
- level  out  n_bits  visible occupancy, 0..2^(n_bits-1).

Behaviour:
- Reset (sysRst=1 at a clk edge): synchroniser chain = 0, rdBin = 0, rdPtrGray = 0.
  - Outputs after reset: empty=1, almostEmpty=1, level=0, rdAddr=0, rdEn=0.
  - sysRst has priority over rdReq.
  - A mid-operation reset discards all pointer state. Resetting the write domain together with it is the integrator's job.
- Synchroniser: wrPtrGray passes through SYNC_STAGES plain flops (no logic between stages) to give wrGraySync.
  - A change on wrPtrGray sampled at edge k appears on wrGraySync after edge k+SYNC_STAGES-1.
  - It affects empty/level in the cycle after that edge.
- Gray to binary: wrBinSync[n_bits-1] = g[n_bits-1]; wrBinSync[i] = wrBinSync[i+1] XOR g[i]. Purely combinational from the final sync stage.
- Flags, all combinational from registers only:
  - empty = (rdPtrGray == wrGraySync).
  - level = (wrBinSync - rdBin) mod 2^n_bits.
  - almostEmpty = (level <= AE_LEVEL).
- Pop: rdEn = rdReq AND NOT empty (combinational). On an edge with rdEn=1:
  - rdBin <= rdBin + 1, wrapping mod 2^n_bits.
  - rdPtrGray <= (rdBin+1) XOR ((rdBin+1) >> 1).
- rdReq while empty: ignored, pointers hold, no error flag.
- rdAddr = rdBin[n_bits-2:0]. It points at the entry being read when rdEn=1, and the data is the RAM's responsibility.
- Wrap: the pointer rolls over from 2^n_bits-1 to 0. The Gray output then changes exactly one bit; empty and level stay correct across the wrap.
- Full FIFO: level = 2^(n_bits-1), i.e. the MSB and the next bit differ and the rest are equal. It is reported as level only; full detection belongs to the write side.
- Simultaneous pop and a wrGraySync update in the same cycle: both apply. The next-cycle level = old level + write delta - 1.
- Invariants:
  - rdPtrGray changes by at most one bit per edge.
  - level never exceeds 2^(n_bits-1) while the write side is well-behaved.
  - Pessimism: empty may stay asserted up to SYNC_STAGES+1 cycles after a write; it is never deasserted early.

Test Plan (n_bits=4, SYNC_STAGES=2, AE_LEVEL=1):
- Reset: hold sysRst for 2 cycles with rdReq=1 and wrPtrGray=0 -> empty=1, almostEmpty=1, level=0, rdPtrGray=0, rdAddr=0, rdEn=0 throughout.
- Latency: wrPtrGray changes 0 -> 1 (Gray of 1), sampled at edge k -> empty falls and level=1 in the cycle after edge k+1. rdReq=1 then gives rdEn=1 for one cycle, rdPtrGray=0001, and empty=1 again.
- Level and almostEmpty: wrPtrGray = Gray(5) = 0111 held, no reads -> level=5, almostEmpty=0. Pop 4 times -> level steps 4, 3, 2, 1; almostEmpty=1 at level 1; rdAddr steps 0 to 4.
- Underflow: empty=1 with rdReq held for 10 cycles -> rdEn=0, and rdBin and rdPtrGray unchanged.
- Wrap: stream 40 entries with write-side Gray stepping and a continuous pop -> rdPtrGray follows 0000 ... 1000 and back to 0000 with exactly one bit change per edge; level stays in 0..8; empty=1 at the end.
- Full and mid-operation reset:
  - wrPtrGray = Gray(8) = 1100 with the read pointer at 0 -> level=8, empty=0.
  - Assert sysRst for 1 cycle while rdReq=1 -> the next cycle has rdPtrGray=0, level=0, empty=1. The synchroniser reloads from the held input within 2 cycles, after which level=8.
